// File: rtl/cpu54_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu54_mem_pkg
// Brief    : Shared size encodings, FSM states and alignment helper for the
//            CPU54 data-memory access path.
// Revision : 1.0
// ============================================================================
package cpu54_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_NONE = 2'b00;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RD   = 5'b00010,
    WR   = 5'b00100,
    DONE = 5'b01000,
    ERR  = 5'b10000
  } state_t;

  // Size 00 is treated as a misaligned access so it takes the error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_NONE) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_merge_unit
// Brief    : Little-endian lane merge for sub-word stores and lane extract with
//            sign/zero extension for loads.
// Revision : 1.0
// ============================================================================
module store_merge_unit
  import cpu54_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{lane, 3'b000} +: 8];
  assign w_half = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    merged   = rdata;
    load_val = rdata;
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        load_val = {{24{sext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_val = {{16{sext & w_half[15]}}, w_half};
      end
      default: begin
        merged   = wdata;
        load_val = rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : store_rmw_ctrl
// Brief    : Sequences CPU54 loads/stores against a word-wide data RAM, using
//            read-modify-write for byte and halfword stores.
// Revision : 1.0
// ============================================================================
module store_rmw_ctrl
  import cpu54_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int             c_TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = (TIMEOUT_CYCLES > 0) ? c_TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit             c_TO_EN   = (TIMEOUT_CYCLES > 0);

  state_t          r_state;
  logic            r_we;
  logic            r_sext;
  logic [1:0]      r_size;
  logic [1:0]      r_lane;
  logic [31:0]     r_wdata;
  logic [c_TW-1:0] r_cnt;

  logic [31:0] w_merged;
  logic [31:0] w_load;
  logic        w_timeout;

  store_merge_unit u_merge (
    .size     (r_size),
    .lane     (r_lane),
    .sext     (r_sext),
    .wdata    (r_wdata),
    .rdata    (mem_rdata),
    .merged   (w_merged),
    .load_val (w_load)
  );

  // An ack in the last allowed cycle wins over the timeout.
  assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST) && !mem_ack;
  assign cpu_busy  = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_sext    <= 1'b0;
      r_size    <= SZ_NONE;
      r_lane    <= 2'b00;
      r_wdata   <= 32'd0;
      r_cnt     <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'd0;
      unique case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_size  <= cpu_size;
            r_sext  <= cpu_sext;
            r_lane  <= cpu_addr[1:0];
            r_wdata <= cpu_wdata;
            r_cnt   <= '0;
            if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
              r_state <= ERR;
              cpu_err <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= cpu_addr[31:2];
              if (cpu_we && (cpu_size == SZ_WORD)) begin
                r_state   <= WR;
                mem_we    <= 1'b1;
                mem_wdata <= cpu_wdata;
              end else begin
                r_state <= RD;
                mem_we  <= 1'b0;
              end
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            if (r_we) begin
              // mem_req stays high straight into the write-back phase.
              r_state   <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= w_merged;
              r_cnt     <= '0;
            end else begin
              r_state   <= DONE;
              mem_req   <= 1'b0;
              cpu_done  <= 1'b1;
              cpu_rdata <= w_load;
            end
          end else if (w_timeout) begin
            r_state <= ERR;
            mem_req <= 1'b0;
            cpu_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR: begin
          if (mem_ack || w_timeout) begin
            r_state   <= mem_ack ? DONE : ERR;
            cpu_done  <= mem_ack;
            cpu_err   <= !mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_rmw_ctrl
// Brief    : Scoreboard bench for store_rmw_ctrl with a behavioural word RAM.
// Revision : 1.0
// ============================================================================
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_sext = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  store_rmw_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    bit          wr;
    logic [29:0] waddr;
    logic [31:0] wdata;
    int          reqc;
  } exp_t;
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ram [0:255];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  int          ph = 0;
  int          req_cycles = 0;
  int          we_cycles = 0;
  logic [29:0] ph_addr = 30'd0;
  logic        ph_we = 1'b0;
  logic [31:0] ph_wdata = 32'd0;
  bit          ph_bad = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input bit err, input logic [31:0] rd, input int lat,
                              input bit wr, input logic [29:0] wa, input logic [31:0] wd,
                              input int reqc);
    exp_t e;
    e.err = err; e.rdata = rd; e.lat = lat; e.wr = wr;
    e.waddr = wa; e.wdata = wd; e.reqc = reqc;
    return e;
  endfunction

  // Word RAM responder: ack after ack_delay waiting cycles per phase.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        ph = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
      end else begin
        req_cycles++;
        if (mem_we) we_cycles++;
        if (ph == 0) begin
          ph_addr = mem_addr; ph_we = mem_we; ph_wdata = mem_wdata; ph_bad = 1'b0;
        end else if ({mem_addr, mem_we, mem_wdata} !== {ph_addr, ph_we, ph_wdata}) begin
          ph_bad = 1'b1;
        end
        if (!ack_never && ph >= ack_delay) begin
          mem_ack = 1'b1;
          chk("phase_stable", 32'(ph_bad), 32'd0);
          if (mem_we) begin
            ram[mem_addr[7:0]] = mem_wdata;
            wr_q.push_back(wr_t'{mem_addr, mem_wdata});
            mem_rdata = 32'd0;
          end else begin
            mem_rdata = ram[mem_addr[7:0]];
          end
          ph = 0;
        end else begin
          mem_ack = 1'b0;
          ph++;
        end
      end
    end
  end

  task automatic access(input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input exp_t e);
    exp_t g;
    wr_t  w;
    int   t0;
    bit   seen;
    seen = 1'b0;
    @(negedge clk);
    wr_q.delete();
    req_cycles = 0;
    we_cycles = 0;
    exp_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_sext = sx;
    cpu_addr = a; cpu_wdata = wd;
    t0 = cyc;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cpu_done || cpu_err) seen = 1'b1;
    end
    g = exp_q.pop_front();
    if (!seen) begin
      chk("response_wait", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(cyc - t0), 32'(g.lat));
      chk("cpu_err", 32'(cpu_err), 32'(g.err));
      chk("cpu_done", 32'(cpu_done), 32'(!g.err));
      chk("cpu_rdata", cpu_rdata, g.rdata);
      chk("req_cycles", 32'(req_cycles), 32'(g.reqc));
      if (g.wr) begin
        chk("write_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("write_addr", 32'(w.a), 32'(g.waddr));
          chk("write_data", w.d, g.wdata);
        end
      end else begin
        chk("no_write_phase", 32'(we_cycles), 32'd0);
      end
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_req, mem_we}), 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Sub-word stores (read-modify-write)
    ram[8'h40] = 32'h11223344;
    access(1, 2'b01, 0, 32'h101, 32'h000000AB, mk(0, 0, 3, 1, 30'h40, 32'h1122AB44, 2));
    ram[8'h40] = 32'h11223344;
    access(1, 2'b10, 0, 32'h102, 32'h0000BEEF, mk(0, 0, 3, 1, 30'h40, 32'hBEEF3344, 2));
    ram[8'h40] = 32'h11223344;
    access(1, 2'b01, 0, 32'h100, 32'hFFFFFF5A, mk(0, 0, 3, 1, 30'h40, 32'h1122335A, 2));
    access(1, 2'b10, 0, 32'h100, 32'h1234CAFE, mk(0, 0, 3, 1, 30'h40, 32'h1122CAFE, 2));

    // Misaligned / illegal size: error, no memory phase
    access(1, 2'b10, 0, 32'h101, 32'h0000BEEF, mk(1, 0, 1, 0, 0, 0, 0));
    access(1, 2'b00, 0, 32'h100, 32'h00000001, mk(1, 0, 1, 0, 0, 0, 0));
    access(1, 2'b11, 0, 32'h202, 32'h00000001, mk(1, 0, 1, 0, 0, 0, 0));
    access(0, 2'b11, 0, 32'h201, 32'h00000000, mk(1, 0, 1, 0, 0, 0, 0));

    // Loads with extension
    ram[8'h40] = 32'h80FF0000;
    access(0, 2'b01, 1, 32'h103, 0, mk(0, 32'hFFFFFF80, 2, 0, 0, 0, 1));
    access(0, 2'b01, 0, 32'h103, 0, mk(0, 32'h00000080, 2, 0, 0, 0, 1));
    access(0, 2'b01, 1, 32'h102, 0, mk(0, 32'hFFFFFFFF, 2, 0, 0, 0, 1));
    access(0, 2'b10, 1, 32'h102, 0, mk(0, 32'hFFFF80FF, 2, 0, 0, 0, 1));
    access(0, 2'b10, 0, 32'h102, 0, mk(0, 32'h000080FF, 2, 0, 0, 0, 1));
    access(0, 2'b11, 1, 32'h100, 0, mk(0, 32'h80FF0000, 2, 0, 0, 0, 1));

    // Word stores, zero-wait and delayed ack
    access(1, 2'b11, 0, 32'h200, 32'h01020304, mk(0, 0, 2, 1, 30'h80, 32'h01020304, 1));
    ack_delay = 3;
    access(1, 2'b11, 0, 32'h200, 32'hDEADBEEF, mk(0, 0, 5, 1, 30'h80, 32'hDEADBEEF, 4));
    access(1, 2'b01, 0, 32'h203, 32'h00000077, mk(0, 0, 9, 1, 30'h80, 32'h77ADBEEF, 8));
    ack_delay = 0;

    // Timeout in RD of a sub-word store: no write phase, back to IDLE
    ack_never = 1'b1;
    ram[8'h40] = 32'h11223344;
    access(1, 2'b01, 0, 32'h101, 32'h000000AB, mk(1, 0, 5, 0, 0, 0, 4));
    @(negedge clk);
    chk("idle_after_timeout", 32'({cpu_busy, mem_req}), 32'd0);
    chk("ram_intact", ram[8'h40], 32'h11223344);

    // Asynchronous reset in the middle of a write phase
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b11; cpu_sext = 1'b0;
    cpu_addr = 32'h200; cpu_wdata = 32'h12345678;
    @(negedge clk);
    chk("pre_reset_wr", 32'({mem_req, mem_we}), 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_req, mem_we}), 32'd0);
    chk("async_rst_data", mem_wdata | cpu_rdata | 32'(mem_addr), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_never = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'({cpu_busy, mem_req}), 32'd0);
    access(1, 2'b11, 0, 32'h204, 32'hCAFEF00D, mk(0, 0, 2, 1, 30'h81, 32'hCAFEF00D, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
